tick_timer_sched: RTL and testbench

- Multi-channel countdown scheduler built on one shared prescaler. The prescaler generates a slow tick, 2 Hz at the 100 MHz board clock by default.
- Up to N_CH independent channels (game/alarm/display timers) share this timebase. Each channel is started, stopped and paused through a single command port.
- Each channel reports a one-cycle expire pulse and can be read back.
- Sits between the top-level control FSM and the functional units needing second-scale timing; replaces per-unit dividers.

---
 rtl/tick_timer_sched.sv | 157 +++++++++++++++
 tb/tb_tick_timer_sched.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_timer_sched.sv
// Multi-channel countdown scheduler sharing one prescaler tick.
// Channels are controlled through a single command port and read back through a registered mux.
module tick_timer_sched #(
  parameter int unsigned PRESCALE = 50_000_000,
  parameter int unsigned N_CH     = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [2:0]       cmd_ch,
  input  logic [1:0]       cmd_op,
  input  logic             cmd_periodic,
  input  logic [CNT_W-1:0] cmd_period,
  output logic             cmd_err,
  input  logic [2:0]       rd_ch,
  output logic [CNT_W-1:0] rd_remain,
  output logic             tick,
  output logic [N_CH-1:0]  busy,
  output logic [N_CH-1:0]  paused,
  output logic [N_CH-1:0]  expire
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] CNT_MAX = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE} state_e;
  typedef enum logic [1:0] {OP_NOP, OP_START, OP_STOP, OP_TOGGLE} op_e;

  state_e           state_q  [N_CH];
  state_e           state_d  [N_CH];
  logic [CNT_W-1:0] remain_q [N_CH];
  logic [CNT_W-1:0] remain_d [N_CH];
  logic [CNT_W-1:0] period_q [N_CH];
  logic [CNT_W-1:0] period_d [N_CH];
  logic [N_CH-1:0]  periodic_q, periodic_d;
  logic [PW-1:0]    cnt_q, cnt_d;
  logic             cmd_err_q, cmd_err_d;
  logic [N_CH-1:0]  expire_q, expire_d;
  logic [N_CH-1:0]  busy_q, busy_d;
  logic [N_CH-1:0]  paused_q, paused_d;
  logic [CNT_W-1:0] rd_remain_q, rd_remain_d;

  logic            ch_ok, start_zero, cmd_ok;
  logic [N_CH-1:0] hit;
  logic            any_run, any_run_d, tick_w;

  always_comb begin
    ch_ok      = {1'b0, cmd_ch} < 4'(N_CH);
    start_zero = (cmd_op == OP_START) && (cmd_period == '0);
    cmd_err_d  = cmd_valid && (!ch_ok || start_zero);
    cmd_ok     = cmd_valid && ch_ok && !start_zero && (cmd_op != OP_NOP);
    hit        = '0;
    any_run    = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      hit[i] = cmd_ok && (cmd_ch == 3'(i));
      if (state_q[i] == ST_RUN) any_run = 1'b1;
    end
    tick_w = any_run && (cnt_q == CNT_MAX);
  end

  // An accepted command on a channel takes precedence over that channel's tick.
  always_comb begin
    expire_d   = '0;
    periodic_d = periodic_q;
    for (int unsigned i = 0; i < N_CH; i++) begin
      state_d[i]  = state_q[i];
      remain_d[i] = remain_q[i];
      period_d[i] = period_q[i];
      if (hit[i]) begin
        case (cmd_op)
          OP_START: begin
            state_d[i]    = ST_RUN;
            remain_d[i]   = cmd_period;
            period_d[i]   = cmd_period;
            periodic_d[i] = cmd_periodic;
          end
          OP_STOP: begin
            state_d[i]  = ST_IDLE;
            remain_d[i] = '0;
          end
          OP_TOGGLE: begin
            if (state_q[i] == ST_RUN)        state_d[i] = ST_PAUSE;
            else if (state_q[i] == ST_PAUSE) state_d[i] = ST_RUN;
          end
          default: ;
        endcase
      end else if (tick_w && (state_q[i] == ST_RUN)) begin
        if (remain_q[i] > CNT_W'(1)) begin
          remain_d[i] = remain_q[i] - CNT_W'(1);
        end else begin
          expire_d[i] = 1'b1;
          if (periodic_q[i]) begin
            remain_d[i] = period_q[i];
          end else begin
            state_d[i]  = ST_IDLE;
            remain_d[i] = '0;
          end
        end
      end
    end
  end

  // Clearing the count when the last runner leaves RUN gives a resume a full prescale period.
  always_comb begin
    any_run_d   = 1'b0;
    busy_d      = '0;
    paused_d    = '0;
    rd_remain_d = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (state_d[i] == ST_RUN) any_run_d = 1'b1;
      busy_d[i]   = (state_d[i] != ST_IDLE);
      paused_d[i] = (state_d[i] == ST_PAUSE);
      if (rd_ch == 3'(i)) rd_remain_d = remain_q[i];
    end
    if (!any_run || !any_run_d || tick_w) cnt_d = '0;
    else                                  cnt_d = cnt_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        state_q[i]  <= ST_IDLE;
        remain_q[i] <= '0;
        period_q[i] <= '0;
      end
      periodic_q  <= '0;
      cnt_q       <= '0;
      cmd_err_q   <= 1'b0;
      expire_q    <= '0;
      busy_q      <= '0;
      paused_q    <= '0;
      rd_remain_q <= '0;
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        state_q[i]  <= state_d[i];
        remain_q[i] <= remain_d[i];
        period_q[i] <= period_d[i];
      end
      periodic_q  <= periodic_d;
      cnt_q       <= cnt_d;
      cmd_err_q   <= cmd_err_d;
      expire_q    <= expire_d;
      busy_q      <= busy_d;
      paused_q    <= paused_d;
      rd_remain_q <= rd_remain_d;
    end
  end

  assign cmd_err   = cmd_err_q;
  assign rd_remain = rd_remain_q;
  assign tick      = tick_w;
  assign busy      = busy_q;
  assign paused    = paused_q;
  assign expire    = expire_q;

endmodule

// File: tb/tb_tick_timer_sched.sv
// Directed bench for tick_timer_sched: per-cycle comparison against a behavioural channel
// model, plus hand-computed expectations on the key scenarios.
module tb_tick_timer_sched;

  localparam int PRESCALE = 4;
  localparam int N_CH     = 4;
  localparam int CNT_W    = 8;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic [2:0]       cmd_ch;
  logic [1:0]       cmd_op;
  logic             cmd_periodic;
  logic [CNT_W-1:0] cmd_period;
  logic             cmd_err;
  logic [2:0]       rd_ch;
  logic [CNT_W-1:0] rd_remain;
  logic             tick;
  logic [N_CH-1:0]  busy, paused, expire;

  tick_timer_sched #(.PRESCALE(PRESCALE), .N_CH(N_CH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ch(cmd_ch), .cmd_op(cmd_op),
    .cmd_periodic(cmd_periodic), .cmd_period(cmd_period), .cmd_err(cmd_err),
    .rd_ch(rd_ch), .rd_remain(rd_remain), .tick(tick), .busy(busy),
    .paused(paused), .expire(expire)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Behavioural model: channel records updated once per clock edge.
  int              m_state    [N_CH];
  int              m_remain   [N_CH];
  int              m_period   [N_CH];
  int              m_periodic [N_CH];
  int              m_cnt;
  bit              m_ok = 1'b0;
  bit              e_err;
  logic [N_CH-1:0] e_expire, e_busy, e_paused;
  int              e_rd;

  function automatic int model_running();
    for (int i = 0; i < N_CH; i++) if (m_state[i] == M_RUN) return 1;
    return 0;
  endfunction

  always @(posedge clk) begin
    int rb, ra, t, claim;
    int old_rem [N_CH];
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        m_state[i] = M_IDLE; m_remain[i] = 0; m_period[i] = 0; m_periodic[i] = 0;
      end
      m_cnt = 0; e_err = 0; e_expire = '0; e_rd = 0;
    end else begin
      rb = model_running();
      t  = (rb != 0 && m_cnt == PRESCALE - 1) ? 1 : 0;
      for (int i = 0; i < N_CH; i++) old_rem[i] = m_remain[i];
      e_err = 0; e_expire = '0; claim = -1;
      if (cmd_valid) begin
        if (int'(cmd_ch) >= N_CH || (cmd_op == 2'b01 && cmd_period == 0)) e_err = 1;
        else if (cmd_op != 2'b00) claim = int'(cmd_ch);
      end
      for (int i = 0; i < N_CH; i++) begin
        if (i == claim) begin
          case (cmd_op)
            2'b01: begin
              m_state[i] = M_RUN; m_remain[i] = int'(cmd_period);
              m_period[i] = int'(cmd_period); m_periodic[i] = int'(cmd_periodic);
            end
            2'b10: begin m_state[i] = M_IDLE; m_remain[i] = 0; end
            default: begin
              if (m_state[i] == M_RUN) m_state[i] = M_PAUSE;
              else if (m_state[i] == M_PAUSE) m_state[i] = M_RUN;
            end
          endcase
        end else if (t != 0 && m_state[i] == M_RUN) begin
          if (m_remain[i] > 1) m_remain[i]--;
          else begin
            e_expire[i] = 1'b1;
            if (m_periodic[i] != 0) m_remain[i] = m_period[i];
            else begin m_state[i] = M_IDLE; m_remain[i] = 0; end
          end
        end
      end
      ra = model_running();
      if (rb == 0 || ra == 0 || t != 0) m_cnt = 0;
      else m_cnt++;
      e_rd = 0;
      for (int i = 0; i < N_CH; i++) if (i == int'(rd_ch)) e_rd = old_rem[i];
    end
    for (int i = 0; i < N_CH; i++) begin
      e_busy[i]   = (m_state[i] != M_IDLE);
      e_paused[i] = (m_state[i] == M_PAUSE);
    end
    m_ok = 1'b1;
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("model_cmd_err", int'(cmd_err), int'(e_err));
      chk("model_tick", int'(tick), (model_running() != 0 && m_cnt == PRESCALE - 1) ? 1 : 0);
      chk("model_busy", int'(busy), int'(e_busy));
      chk("model_paused", int'(paused), int'(e_paused));
      chk("model_expire", int'(expire), int'(e_expire));
      chk("model_rd_remain", int'(rd_remain), e_rd);
    end
  end

  // Called at a negedge: the command is sampled at the next posedge; returns at the following negedge.
  task automatic issue(input int ch, input int op, input int per, input bit per_mode);
    cmd_valid = 1'b1; cmd_ch = 3'(ch); cmd_op = 2'(op);
    cmd_period = CNT_W'(per); cmd_periodic = per_mode;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_period = '0; cmd_periodic = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_ch = '0; cmd_op = '0;
    cmd_periodic = 1'b0; cmd_period = '0; rd_ch = '0;
    idle(2);
    chk("rst_busy", int'(busy), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_expire", int'(expire), 0);
    chk("rst_rd", int'(rd_remain), 0);
    rst = 1'b0;
    idle(1);

    // One-shot ch0, period 3: ticks after E3/E7/E11, expire after E12
    rd_ch = 3'd0;
    issue(0, 1, 3, 1'b0);
    chk("os_busy_start", int'(busy[0]), 1);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      chk("os_tick", int'(tick), (k == 3 || k == 7 || k == 11) ? 1 : 0);
      chk("os_expire", int'(expire[0]), (k == 12) ? 1 : 0);
      chk("os_busy", int'(busy[0]), (k < 12) ? 1 : 0);
      if (k == 1)  chk("os_rd3", int'(rd_remain), 3);
      if (k == 5)  chk("os_rd2", int'(rd_remain), 2);
      if (k == 9)  chk("os_rd1", int'(rd_remain), 1);
      if (k == 13) chk("os_rd0", int'(rd_remain), 0);
    end

    // Periodic ch1, period 2: expire after E8, E16, E24; STOP sampled at E30
    rd_ch = 3'd1;
    issue(1, 1, 2, 1'b1);
    for (int k = 1; k <= 29; k++) begin
      @(negedge clk);
      chk("per_expire", int'(expire[1]), (k % 8 == 0) ? 1 : 0);
      chk("per_busy", int'(busy[1]), 1);
    end
    issue(1, 2, 0, 1'b0);
    chk("per_stop_busy", int'(busy[1]), 0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("per_no_expire", int'(expire[1]), 0);
    end

    // ch2 period 5, pause after two ticks, hold, resume
    rd_ch = 3'd2;
    issue(2, 1, 5, 1'b0);
    idle(8);
    issue(2, 3, 0, 1'b0);
    chk("pause_flag", int'(paused[2]), 1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("pause_tick", int'(tick), 0);
      chk("pause_rd", int'(rd_remain), 3);
      chk("pause_busy", int'(busy[2]), 1);
    end
    issue(2, 3, 0, 1'b0);
    chk("resume_flag", int'(paused[2]), 0);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      chk("resume_expire", int'(expire[2]), (k == 12) ? 1 : 0);
    end

    // STOP ch0 in its final tick cycle while ch3 decrements 2 -> 1
    rd_ch = 3'd3;
    issue(3, 1, 3, 1'b0);
    issue(0, 1, 2, 1'b0);
    idle(6);
    chk("race_tick", int'(tick), 1);
    issue(0, 2, 0, 1'b0);
    chk("race_busy0", int'(busy[0]), 0);
    chk("race_expire0", int'(expire[0]), 0);
    chk("race_busy3", int'(busy[3]), 1);
    for (int k = 9; k <= 13; k++) begin
      @(negedge clk);
      chk("race_no_expire0", int'(expire[0]), 0);
      chk("race_expire3", int'(expire[3]), (k == 12) ? 1 : 0);
      if (k == 9) chk("race_rd3", int'(rd_remain), 1);
    end

    // Rejected commands and PAUSE on an idle channel
    issue(5, 1, 3, 1'b0);
    chk("err_bad_ch", int'(cmd_err), 1);
    chk("err_bad_ch_busy", int'(busy), 0);
    @(negedge clk);
    chk("err_pulse_end", int'(cmd_err), 0);
    issue(0, 1, 0, 1'b0);
    chk("err_zero_period", int'(cmd_err), 1);
    chk("err_zero_busy", int'(busy), 0);
    issue(1, 3, 0, 1'b0);
    chk("pause_idle_err", int'(cmd_err), 0);
    chk("pause_idle_busy", int'(busy), 0);
    chk("pause_idle_paused", int'(paused), 0);

    // Reset while ch0 (remain 2) and ch1 (remain 4) run
    rd_ch = 3'd1;
    issue(0, 1, 3, 1'b0);
    issue(1, 1, 5, 1'b0);
    idle(3);
    chk("pre_rst_busy", int'(busy), 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_expire", int'(expire), 0);
    chk("mid_rst_rd", int'(rd_remain), 0);
    chk("mid_rst_err", int'(cmd_err), 0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("post_rst_tick", int'(tick), 0);
      chk("post_rst_expire", int'(expire), 0);
      chk("post_rst_busy", int'(busy), 0);
    end

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
